prog_loader: RTL and testbench
==============================

# prog_loader

Program-load sequencer that drives the CPU's instruction-load port from a byte-serial host stream. It receives a length-prefixed program image over a valid/ready byte interface and buffers it completely. It then holds the CPU in reset, bursts the words into the CPU's `LoadInstructions`/`Instruction` port on consecutive cycles, and pulses `Reset` once more so the CPU starts at word 0. It replaces hand-driven load sequences at the CPU's top level.

## Interface
- `MAX_WORDS`, 64: buffer capacity in 32-bit words; power of two, at most 65535.
- `AW`, `$clog2(MAX_WORDS)`: buffer address width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `Reset`  in  1  asynchronous, active-high.
- `start`  in  1  one-cycle pulse; begins a load session; honoured only in IDLE, DONE or ERR.
- `byte_valid`  in  1  host byte present.
- `byte_data`  in  8  host byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `cpu_load`  out  1  connects to CPU `LoadInstructions`.
- `cpu_instr`  out  32  connects to CPU `Instruction`.
- `cpu_reset`  out  1  connects to CPU `Reset`.
- `busy`  out  1  session in progress.
- `done`  out  1  level; program loaded and CPU released.
- `err`  out  1  level; session aborted.
- `words_loaded`  out  16  words burst into the CPU in the last session.

## Operation
- Image format, big-endian:
  - 2-byte word count N.
  - N×4 bytes; the first byte of each word is bits [31:24].
  - With `PROG_LOADER_CHECKSUM_EN` only: one trailing checksum byte.
- A byte transfers on a rising edge where `byte_valid && byte_ready` is true. `byte_ready` is high only in HDR0, HDR1, COLLECT and CSUM.
- States:
  - IDLE: `start` → HDR0.
  - HDR0: byte accept → HDR1.
  - HDR1: byte accept → COLLECT; goes to ERR instead if N==0 or N>MAX_WORDS.
  - COLLECT: packs 4 bytes into one word and writes it to the buffer. After the 4N-th byte → CSUM if the macro is defined, otherwise → PRE_RST.
  - CSUM: byte accept → PRE_RST if it matches, otherwise → ERR.
  - PRE_RST: one cycle; issues the buffer read of word 0.
  - BURST: N cycles; `cpu_load`=1, `cpu_instr`=word k on cycle k.
  - POST_RST: one cycle → DONE.
  - DONE: `done`=1; `start` → HDR0.
  - ERR: `err`=1; `start` → HDR0.
- `cpu_reset` is 1 in every state except DONE. The CPU is held idle during reception and released only after a complete burst.
- `cpu_load` is 1 only in BURST and is never asserted with `cpu_reset`=1.
- `cpu_instr` is 0 outside BURST.
- `busy` is 1 in HDR0 through POST_RST.
- `start` clears `done`, `err` and `words_loaded`. `start` while `busy` is ignored.
- The byte-in-word counter and word counter are reset on every `start`. A partial word never leaks into a following session.
- `words_loaded` is updated to N on entry to DONE.

## Timing
- Reset values:
  - State = IDLE.
  - `cpu_reset`=1.
  - `cpu_load`=0, `cpu_instr`=0, `byte_ready`=0, `busy`=0, `done`=0, `err`=0, `words_loaded`=0.
- Asserting `Reset` mid-session aborts immediately and returns to these values; buffer contents are don't-care.
- All outputs are registered. The buffer has a synchronous read with 1-cycle latency; PRE_RST covers it, so BURST carries no bubbles.
- The last accepted image byte is at edge E:
  - PRE_RST occupies the cycle after E.
  - BURST occupies cycles E+2 … E+N+1.
  - POST_RST occupies cycle E+N+2.
  - `done` rises at E+N+3, together with `cpu_reset` falling.
- The host may stall (`byte_valid`=0) for any number of cycles. The loader never deasserts `byte_ready` mid-image.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined:
  - A checksum byte follows the payload. It equals the XOR of all header and payload bytes.
  - On mismatch the session goes to ERR and no `cpu_load` is issued.
- Not defined: there is no CSUM state, and COLLECT → PRE_RST directly.

## Structure
- Package `prog_loader_pkg`: state enum, header byte count (2), word byte count (4), `CPU_WORD_W`=32.
- Sub-module `prog_buf`: simple dual-port RAM of MAX_WORDS×32 with synchronous write and synchronous registered read. The FSM and byte packer stay in `prog_loader`.

## Test plan
- 11-word program: addi R1,423 … add R8,R7,R2, N=0x000B → 11 consecutive `cpu_load` cycles in byte order, `cpu_reset` pulses around the burst, `done`=1, `words_loaded`=11.
- Same image with random `byte_valid` gaps of 0–5 cycles → identical burst; burst-to-done latency is exactly N+3 cycles from the last byte.
- N=0, then N=MAX_WORDS+1 → ERR after HDR1, `err`=1, no `cpu_load`, `cpu_reset` stays 1.
- `Reset` pulsed after 6 payload bytes, then a fresh `start` with a 1-word image 0x2001_01A7 → a single-cycle burst of 0x200101A7 with no stale bytes.
- `start` pulsed during BURST → ignored; burst completes unchanged.
- With `PROG_LOADER_CHECKSUM_EN`: correct XOR → DONE; flipping one checksum bit → ERR with zero `cpu_load` cycles.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: states and constants shared by the program loader and its buffer.
// The CSUM state exists only when PROG_LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int CPU_WORD_W = 32;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_COLLECT,
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_PRE_RST,
        S_BURST,
        S_POST_RST,
        S_DONE,
        S_ERR
    } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t COLLECT_NEXT = S_CSUM;
    localparam int     CSUM_BYTES   = 1;
`else
    localparam state_t COLLECT_NEXT = S_PRE_RST;
    localparam int     CSUM_BYTES   = 0;
`endif

    function automatic logic accepts_bytes(input state_t s);
`ifdef PROG_LOADER_CHECKSUM_EN
        return s inside {S_HDR0, S_HDR1, S_COLLECT, S_CSUM};
`else
        return s inside {S_HDR0, S_HDR1, S_COLLECT};
`endif
    endfunction

    function automatic logic in_session(input state_t s);
        return !(s inside {S_IDLE, S_DONE, S_ERR});
    endfunction

    function automatic int image_bytes(input int n);
        return HDR_BYTES + WORD_BYTES * n + CSUM_BYTES;
    endfunction

endpackage

// File: rtl/prog_buf.sv
// prog_buf: simple dual-port word buffer, synchronous write, registered read.
// The read register returns zero when no read is requested, so it can drive cpu_instr directly.
module prog_buf
    import prog_loader_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [CPU_WORD_W-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [CPU_WORD_W-1:0] rdata
);

    logic [CPU_WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= '0;
        else
            rdata <= re ? mem[raddr] : '0;
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: buffers a length-prefixed byte image, then bursts it into the CPU load port.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int MAX_WORDS = 64,
    parameter int AW        = $clog2(MAX_WORDS)
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  cpu_load,
    output logic [CPU_WORD_W-1:0] cpu_instr,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           words_loaded
);

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    state_t      state, nxt;
    logic [15:0] n, wp, hdr_n;
    logic [1:0]  bc;
    logic [23:0] sh;
    logic        take, go, bad_n, last_byte, word_end, we, re;
    logic [AW-1:0] raddr;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign take      = byte_valid && byte_ready;
    assign go        = start && !in_session(state);
    assign hdr_n     = {n[15:8], byte_data};
    assign bad_n     = hdr_n == 16'd0 || hdr_n > MAX_N;
    assign word_end  = bc == 2'(WORD_BYTES - 1);
    assign last_byte = word_end && wp == n - 16'd1;
    assign we        = take && state == S_COLLECT && word_end;
    // wp doubles as the read pointer once collection is over; PRE_RST primes word 0
    assign re        = state == S_PRE_RST || (state == S_BURST && wp != n);
    assign raddr     = state == S_PRE_RST ? '0 : wp[AW-1:0];

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: nxt = start ? S_HDR0 : state;
            S_HDR0:     nxt = take ? S_HDR1 : state;
            S_HDR1:     nxt = !take ? state : bad_n ? S_ERR : S_COLLECT;
            S_COLLECT:  nxt = take && last_byte ? COLLECT_NEXT : state;
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM:     nxt = !take ? state : byte_data == csum ? S_PRE_RST : S_ERR;
`endif
            S_PRE_RST:  nxt = S_BURST;
            S_BURST:    nxt = wp == n ? S_POST_RST : state;
            S_POST_RST: nxt = S_DONE;
            default:    nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state        <= S_IDLE;
            n            <= '0;
            wp           <= '0;
            bc           <= '0;
            sh           <= '0;
            byte_ready   <= 1'b0;
            cpu_load     <= 1'b0;
            cpu_reset    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            state      <= nxt;
            byte_ready <= accepts_bytes(nxt);
            cpu_load   <= nxt == S_BURST;
            cpu_reset  <= nxt != S_DONE;
            busy       <= in_session(nxt);
            done       <= nxt == S_DONE;
            err        <= nxt == S_ERR;
            if (go) begin
                bc           <= '0;
                wp           <= '0;
                words_loaded <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum         <= '0;
`endif
            end
            if (take && state == S_HDR0)
                n <= {byte_data, 8'h00};
            if (take && state == S_HDR1)
                n[7:0] <= byte_data;
            if (take && state == S_COLLECT) begin
                bc <= bc + 2'd1;
                sh <= {sh[15:0], byte_data};
                if (word_end)
                    wp <= wp + 16'd1;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            if (take && state != S_CSUM)
                csum <= csum ^ byte_data;
`endif
            if (state == S_PRE_RST)
                wp <= 16'd1;
            if (state == S_BURST && wp != n)
                wp <= wp + 16'd1;
            if (state == S_POST_RST)
                words_loaded <= n;
        end
    end

    prog_buf #(.DEPTH(MAX_WORDS), .AW(AW)) u_buf (
        .clk   (clk),
        .rst   (Reset),
        .we    (we),
        .waddr (wp[AW-1:0]),
        .wdata ({sh, byte_data}),
        .re    (re),
        .raddr (raddr),
        .rdata (cpu_instr)
    );

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed checks of prog_loader; sends the trailing checksum byte
// when built with PROG_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready, cpu_load, cpu_reset, busy, done, err;
    logic [31:0] cpu_instr;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;
    int loads = 0;
    logic [7:0] xs;
    logic [31:0] prog [0:10] = '{
        32'h200101A7, 32'h20020011, 32'h00221820, 32'h00612022,
        32'h00832824, 32'h00A43025, 32'h0005382A, 32'h20E7FFFF,
        32'h10E20002, 32'hAC030008, 32'h00E24020
    };

    prog_loader #(.MAX_WORDS(64)) dut (
        .clk          (clk),
        .Reset        (Reset),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .cpu_load     (cpu_load),
        .cpu_instr    (cpu_instr),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cpu_load) loads <= loads + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        xs = 8'h00;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        bit ok = 1'b0;
        byte_valid = 1'b0;
        repeat (rnd ? $urandom_range(0, 5) : 0) @(negedge clk);
        byte_valid = 1'b1;
        byte_data = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = byte_ready;
            @(negedge clk);
        end
        byte_valid = 1'b0;
        xs = xs ^ b;
        chk("accept", 32'(ok), 32'd1);
    endtask

    task automatic send_image(input logic [15:0] hdr, input int nw, input bit rnd, input logic [7:0] flip);
        logic [7:0] cs;
        send_byte(hdr[15:8], rnd);
        send_byte(hdr[7:0], rnd);
        for (int w = 0; w < nw; w++)
            for (int b = 3; b >= 0; b--)
                send_byte(prog[w][b*8 +: 8], rnd);
        cs = xs ^ flip;
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(cs, rnd);
`endif
    endtask

    task automatic check_burst(input int nw, input int poke);
        int l0 = loads;
        chk("pre_load", 32'(cpu_load), 32'd0);
        chk("pre_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("pre_busy", 32'(busy), 32'd1);
        for (int k = 0; k < nw; k++) begin
            start = (k == poke);
            @(negedge clk);
            chk("burst_load", 32'(cpu_load), 32'd1);
            chk("burst_instr", cpu_instr, prog[k]);
            chk("burst_cpu_reset", 32'(cpu_reset), 32'd1);
        end
        start = 1'b0;
        @(negedge clk);
        chk("post_load", 32'(cpu_load), 32'd0);
        chk("post_instr", cpu_instr, 32'd0);
        chk("post_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("post_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("done", 32'(done), 32'd1);
        chk("release", 32'(cpu_reset), 32'd0);
        chk("words_loaded", 32'(words_loaded), 32'(nw));
        chk("done_busy", 32'(busy), 32'd0);
        chk("load_cycles", 32'(loads - l0), 32'(nw));
    endtask

    task automatic check_err(input string tag, input int l0);
        chk({tag, "_err"}, 32'(err), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        chk({tag, "_no_load"}, 32'(loads - l0), 32'd0);
    endtask

    initial begin
        int l0;
        #2 Reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_outs", {cpu_instr[27:0], cpu_load, byte_ready, busy, done | err}, 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        Reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_ready", 32'(byte_ready), 32'd0);

        // 11-word program, back-to-back bytes
        pulse_start();
        chk("hdr_ready", 32'(byte_ready), 32'd1);
        chk("hdr_busy", 32'(busy), 32'd1);
        send_image(16'h000B, 11, 1'b0, 8'h00);
        check_burst(11, -1);

        // same image with host stalls; start poked mid-burst
        pulse_start();
        chk("start_clears_done", 32'(done), 32'd0);
        chk("start_clears_words", 32'(words_loaded), 32'd0);
        send_image(16'h000B, 11, 1'b1, 8'h00);
        check_burst(11, 3);

        // N = 0 and N = MAX_WORDS+1 both abort after the header
        l0 = loads;
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        check_err("n0", l0);
        pulse_start();
        chk("start_clears_err", 32'(err), 32'd0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h41, 1'b0);
        check_err("n65", l0);

        // Reset after 6 payload bytes, then a fresh 1-word image
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h0B, 1'b0);
        for (int b = 0; b < 6; b++)
            send_byte(8'hC0 + 8'(b), 1'b0);
        Reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(byte_ready), 32'd0);
        chk("abort_cpu_reset", 32'(cpu_reset), 32'd1);
        @(negedge clk);
        Reset = 1'b0;
        pulse_start();
        send_image(16'h0001, 1, 1'b0, 8'h00);
        check_burst(1, -1);

`ifdef PROG_LOADER_CHECKSUM_EN
        l0 = loads;
        pulse_start();
        send_image(16'h000B, 11, 1'b0, 8'h01);
        check_err("bad_csum", l0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
